// File: rtl/regfile_mp.sv
// Multi-port register file with WB->ID forwarding and a pending-write scoreboard
// that raises a stall request when an enabled read port sources a pending register.

module regfile_mp_rd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     rst,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        raddr,
    input  logic [DATA_W-1:0]        stored,
    input  logic                     pend,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rbusy
);
    logic              hit;
    logic [DATA_W-1:0] hdata;
    logic              zero;

    // Ascending scan so the highest-index matching write port wins.
    always_comb begin
        hit   = 1'b0;
        hdata = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (we[w] && waddr[w*ADDR_W +: ADDR_W] == raddr) begin
                hit   = 1'b1;
                hdata = wdata[w*DATA_W +: DATA_W];
            end
        end
    end

    assign zero = (ZERO_REG != 0) && (raddr == '0);

    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (rst && re && !zero) begin
            rdata = (BYPASS != 0 && hit) ? hdata : stored;
            // Without forwarding, a same-cycle write is not yet visible to the reader.
            rbusy = (BYPASS != 0) ? (pend & ~hit) : (pend | hit);
        end
    end
endmodule

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    output logic                     stall,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    input  logic                     sb_flush,
    output logic                     sb_any
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             pend;
    logic [DEPTH-1:0]             pend_nxt;
    logic [NUM_WR-1:0]            wv;

    // Writes to register 0 are dropped here so neither storage nor forwarding sees them.
    always_comb begin
        for (int w = 0; w < NUM_WR; w++)
            wv[w] = we[w] && !((ZERO_REG != 0) && (waddr[w*ADDR_W +: ADDR_W] == '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++)
                if (wv[w])
                    regs[waddr[w*ADDR_W +: ADDR_W]] <= wdata[w*DATA_W +: DATA_W];
        end
    end

    // Priority low to high: write-back clear, issue set, flush.
    always_comb begin
        pend_nxt = pend;
        for (int w = 0; w < NUM_WR; w++)
            if (wv[w])
                pend_nxt[waddr[w*ADDR_W +: ADDR_W]] = 1'b0;
        if (sb_set && !((ZERO_REG != 0) && (sb_addr == '0)))
            pend_nxt[sb_addr] = 1'b1;
        if (sb_flush)
            pend_nxt = '0;
        if (ZERO_REG != 0)
            pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend   <= '0;
            sb_any <= 1'b0;
        end else begin
            pend   <= pend_nxt;
            sb_any <= |pend_nxt;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_mp_rd #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .NUM_WR  (NUM_WR),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rd (
            .rst   (rst),
            .re    (re[i]),
            .raddr (raddr[i*ADDR_W +: ADDR_W]),
            .stored(regs[raddr[i*ADDR_W +: ADDR_W]]),
            .pend  (pend[raddr[i*ADDR_W +: ADDR_W]]),
            .we    (wv),
            .waddr (waddr),
            .wdata (wdata),
            .rdata (rdata[i*DATA_W +: DATA_W]),
            .rbusy (rbusy[i])
        );
    end

    assign stall = |(re & rbusy);
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp; a forwarding and a non-forwarding
// instance share inputs and are checked against an array-based reference model.

module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    re;
    logic [2*AW-1:0] raddr;
    logic [2*DW-1:0] rdata, rdata_nb;
    logic [1:0]    rbusy, rbusy_nb;
    logic          stall, stall_nb;
    logic [1:0]    we;
    logic [2*AW-1:0] waddr;
    logic [2*DW-1:0] wdata;
    logic          sb_set;
    logic [AW-1:0] sb_addr;
    logic          sb_flush;
    logic          sb_any, sb_any_nb;

    int nvec = 0;
    int nerr = 0;

    logic [DW-1:0] m_mem [32];
    bit            m_pend [32];
    bit            m_any;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .stall(stall),
        .we(we), .waddr(waddr), .wdata(wdata), .sb_set(sb_set), .sb_addr(sb_addr),
        .sb_flush(sb_flush), .sb_any(sb_any));

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb), .stall(stall_nb),
        .we(we), .waddr(waddr), .wdata(wdata), .sb_set(sb_set), .sb_addr(sb_addr),
        .sb_flush(sb_flush), .sb_any(sb_any_nb));

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
        end
        m_any = 1'b0;
    endtask

    // Architectural effect of one rising edge, from the inputs present at that edge.
    task automatic model_edge();
        logic [AW-1:0] a;
        if (!rst) return;
        for (int w = 0; w < 2; w++) begin
            a = waddr[w*AW +: AW];
            if (we[w] && a != 0) m_mem[a] = wdata[w*DW +: DW];
        end
        if (sb_flush) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
        end else begin
            for (int w = 0; w < 2; w++) begin
                a = waddr[w*AW +: AW];
                if (we[w] && a != 0) m_pend[a] = 1'b0;
            end
            if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
        end
        m_any = 1'b0;
        for (int r = 0; r < 32; r++) m_any = m_any | m_pend[r];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic bit wr_match(logic [AW-1:0] a, output logic [DW-1:0] d);
        bit h = 0;
        d = '0;
        for (int w = 0; w < 2; w++)
            if (we[w] && waddr[w*AW +: AW] == a) begin
                h = 1;
                d = wdata[w*DW +: DW];
            end
        return h;
    endfunction

    function automatic logic [DW-1:0] exp_data(int i, bit byp);
        logic [AW-1:0] a = raddr[i*AW +: AW];
        logic [DW-1:0] d;
        bit h;
        if (!rst || !re[i] || a == 0) return '0;
        h = wr_match(a, d);
        return (byp && h) ? d : m_mem[a];
    endfunction

    function automatic logic exp_busy(int i, bit byp);
        logic [AW-1:0] a = raddr[i*AW +: AW];
        logic [DW-1:0] d;
        bit h;
        if (!rst || !re[i] || a == 0) return 1'b0;
        h = wr_match(a, d);
        return byp ? (m_pend[a] && !h) : (m_pend[a] || h);
    endfunction

    task automatic idle();
        re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
        sb_set = 0; sb_addr = '0; sb_flush = 0;
    endtask

    task automatic test_reset();
        rst = 0; model_reset(); idle();
        re = 2'b11; raddr = {5'd9, 5'd5};
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'h1234};
        #3;
        nvec++; if (rdata !== '0 || rdata_nb !== '0) begin nerr++; $display("FAIL reset_rdata: got %h/%h expected 0", rdata, rdata_nb); end
        nvec++; if (rbusy !== 2'b00 || stall !== 1'b0 || sb_any !== 1'b0) begin nerr++; $display("FAIL reset_flags: got rbusy=%b stall=%b sb_any=%b expected 0", rbusy, stall, sb_any); end
        tick(); tick();
        #2 rst = 1;
        tick();
        idle(); we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEAD};
        tick();
        idle(); re = 2'b01; raddr = {5'd0, 5'd5};
        #1;
        nvec++; if (rdata[31:0] !== 32'hDEAD) begin nerr++; $display("FAIL reset_prewrite: got %h expected 0000dead", rdata[31:0]); end
        #2 rst = 0; model_reset();
        #1;
        nvec++; if (rdata[31:0] !== 32'h0 || rdata_nb[31:0] !== 32'h0) begin nerr++; $display("FAIL reset_async_rdata: got %h/%h expected 0", rdata[31:0], rdata_nb[31:0]); end
        #1 rst = 1;
        tick();
        nvec++; if (rdata[31:0] !== 32'h0) begin nerr++; $display("FAIL reset_cleared_r5: got %h expected 00000000", rdata[31:0]); end
    endtask

    task automatic test_write_conflict();
        idle();
        we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h2222, 32'h1111};
        re = 2'b01; raddr = {5'd0, 5'd7};
        #1;
        nvec++; if (rdata[31:0] !== 32'h2222) begin nerr++; $display("FAIL conflict_bypass: got %h expected 00002222", rdata[31:0]); end
        tick();
        we = '0;
        #1;
        nvec++; if (rdata[31:0] !== 32'h2222 || rdata_nb[31:0] !== 32'h2222) begin nerr++; $display("FAIL conflict_stored: got %h/%h expected 00002222", rdata[31:0], rdata_nb[31:0]); end
    endtask

    task automatic test_zero_reg();
        idle();
        we = 2'b10; waddr = {5'd0, 5'd0}; wdata = {32'hFFFFFFFF, 32'h0};
        sb_set = 1; sb_addr = 5'd0;
        re = 2'b11; raddr = {5'd0, 5'd0};
        #1;
        nvec++; if (rdata !== '0 || rbusy !== 2'b00 || rbusy_nb !== 2'b00) begin nerr++; $display("FAIL zero_same_cycle: got %h rbusy=%b/%b expected 0", rdata, rbusy, rbusy_nb); end
        tick();
        idle(); re = 2'b01; raddr = '0;
        #1;
        nvec++; if (rdata[31:0] !== '0 || rbusy[0] !== 1'b0 || sb_any !== 1'b0) begin nerr++; $display("FAIL zero_after: got %h rbusy=%b sb_any=%b expected 0", rdata[31:0], rbusy[0], sb_any); end
    endtask

    task automatic test_scoreboard();
        idle(); sb_set = 1; sb_addr = 5'd3;
        tick();
        idle(); re = 2'b01; raddr = {5'd0, 5'd3};
        #1;
        nvec++; if (rbusy[0] !== 1'b1 || stall !== 1'b1 || sb_any !== 1'b1) begin nerr++; $display("FAIL sb_pending: got rbusy=%b stall=%b sb_any=%b expected 1", rbusy[0], stall, sb_any); end
        we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h55};
        #1;
        nvec++; if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'h55 || stall !== 1'b0) begin nerr++; $display("FAIL sb_writeback: got rbusy=%b rdata=%h stall=%b expected 0/00000055/0", rbusy[0], rdata[31:0], stall); end
        nvec++; if (rbusy_nb[0] !== 1'b1 || stall_nb !== 1'b1) begin nerr++; $display("FAIL sb_writeback_nobypass: got rbusy=%b stall=%b expected 1/1", rbusy_nb[0], stall_nb); end
        tick();
        idle();
        nvec++; if (sb_any !== 1'b0 || sb_any_nb !== 1'b0) begin nerr++; $display("FAIL sb_cleared: got %b/%b expected 0", sb_any, sb_any_nb); end
    endtask

    task automatic test_set_vs_clear();
        idle(); sb_set = 1; sb_addr = 5'd4;
        we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h9};
        tick();
        idle(); re = 2'b01; raddr = {5'd0, 5'd4};
        #1;
        nvec++; if (rdata[31:0] !== 32'h9 || rbusy[0] !== 1'b1 || sb_any !== 1'b1) begin nerr++; $display("FAIL set_beats_clear: got rdata=%h rbusy=%b sb_any=%b expected 00000009/1/1", rdata[31:0], rbusy[0], sb_any); end
        idle(); sb_flush = 1;
        tick();
        idle();
    endtask

    task automatic test_flush();
        idle(); we = 2'b01; waddr = {5'd0, 5'd1}; wdata = {32'h0, 32'h11};
        tick();
        idle(); sb_set = 1; sb_addr = 5'd1;
        tick();
        sb_addr = 5'd2;
        tick();
        idle();
        nvec++; if (sb_any !== 1'b1) begin nerr++; $display("FAIL flush_pre: got %b expected 1", sb_any); end
        sb_flush = 1; sb_set = 1; sb_addr = 5'd6;
        tick();
        idle(); re = 2'b11; raddr = {5'd6, 5'd1};
        #1;
        nvec++; if (sb_any !== 1'b0 || rbusy !== 2'b00 || rbusy_nb !== 2'b00) begin nerr++; $display("FAIL flush_clears: got sb_any=%b rbusy=%b/%b expected 0", sb_any, rbusy, rbusy_nb); end
        we = 2'b01; waddr = {5'd0, 5'd1}; wdata = {32'h0, 32'h77};
        #1;
        nvec++; if (rdata_nb[31:0] !== 32'h11 || rbusy_nb[0] !== 1'b1) begin nerr++; $display("FAIL nobypass_old: got rdata=%h rbusy=%b expected 00000011/1", rdata_nb[31:0], rbusy_nb[0]); end
        nvec++; if (rdata[31:0] !== 32'h77 || rbusy[0] !== 1'b0) begin nerr++; $display("FAIL bypass_new: got rdata=%h rbusy=%b expected 00000077/0", rdata[31:0], rbusy[0]); end
        tick();
        we = '0;
        #1;
        nvec++; if (rdata_nb[31:0] !== 32'h77 || rdata[31:0] !== 32'h77) begin nerr++; $display("FAIL flush_after_write: got %h/%h expected 00000077", rdata[31:0], rdata_nb[31:0]); end
    endtask

    task automatic test_random();
        logic [DW-1:0] ed;
        logic          eb, es;
        for (int n = 0; n < 400; n++) begin
            re       = 2'($urandom);
            raddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            we       = 2'($urandom);
            waddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wdata    = {$urandom, $urandom};
            sb_set   = ($urandom_range(0, 2) == 0);
            sb_addr  = 5'($urandom_range(0, 7));
            sb_flush = ($urandom_range(0, 15) == 0);
            #1;
            for (int i = 0; i < 2; i++) begin
                ed = exp_data(i, 1);
                nvec++; if (rdata[i*DW +: DW] !== ed) begin nerr++; $display("FAIL rand_rdata[%0d] cyc %0d: got %h expected %h", i, n, rdata[i*DW +: DW], ed); end
                ed = exp_data(i, 0);
                nvec++; if (rdata_nb[i*DW +: DW] !== ed) begin nerr++; $display("FAIL rand_rdata_nb[%0d] cyc %0d: got %h expected %h", i, n, rdata_nb[i*DW +: DW], ed); end
                eb = exp_busy(i, 1);
                nvec++; if (rbusy[i] !== eb) begin nerr++; $display("FAIL rand_rbusy[%0d] cyc %0d: got %b expected %b", i, n, rbusy[i], eb); end
                eb = exp_busy(i, 0);
                nvec++; if (rbusy_nb[i] !== eb) begin nerr++; $display("FAIL rand_rbusy_nb[%0d] cyc %0d: got %b expected %b", i, n, rbusy_nb[i], eb); end
            end
            es = exp_busy(0, 1) | exp_busy(1, 1);
            nvec++; if (stall !== es) begin nerr++; $display("FAIL rand_stall cyc %0d: got %b expected %b", n, stall, es); end
            es = exp_busy(0, 0) | exp_busy(1, 0);
            nvec++; if (stall_nb !== es) begin nerr++; $display("FAIL rand_stall_nb cyc %0d: got %b expected %b", n, stall_nb, es); end
            tick();
            nvec++; if (sb_any !== m_any || sb_any_nb !== m_any) begin nerr++; $display("FAIL rand_sb_any cyc %0d: got %b/%b expected %b", n, sb_any, sb_any_nb, m_any); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_conflict();
        test_zero_reg();
        test_scoreboard();
        test_set_vs_clear();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
